asrv32_decoder: RTL and testbench

ASRV32_DECODER -- requirements
Module: asrv32_decoder

---
 rtl/asrv32_pkg.sv | 39 +++
 rtl/asrv32_imm_gen.sv | 26 ++
 rtl/asrv32_decoder.sv | 179 +++++++++++++++++
 tb/tb_asrv32_decoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/asrv32_pkg.sv
// Shared RV32I decode definitions: base opcodes, one-hot class bit
// positions used on o_opcode, and the immediate format selector.
package asrv32_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   localparam int CLS_LOAD   = 0;
   localparam int CLS_STORE  = 1;
   localparam int CLS_OPIMM  = 2;
   localparam int CLS_OP     = 3;
   localparam int CLS_BRANCH = 4;
   localparam int CLS_JAL    = 5;
   localparam int CLS_JALR   = 6;
   localparam int CLS_LUI    = 7;
   localparam int CLS_AUIPC  = 8;
   localparam int CLS_SYSTEM = 9;
   localparam int CLS_FENCE  = 10;
   localparam int NUM_CLS    = 11;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5
   } fmt_e;

endpackage

// File: rtl/asrv32_imm_gen.sv
// Combinational RV32I immediate extraction: instruction word plus format
// selector in, sign-extended 32-bit immediate out (0 for FMT_NONE).
module asrv32_imm_gen
   import asrv32_pkg::*;
(
   input  logic [31:0] i_inst,
   input  logic [2:0]  i_fmt,
   output logic [31:0] o_imm
);

   // Assemble the immediate for the selected encoding format
   always_comb begin
      o_imm = 32'd0;
      case (i_fmt)
         FMT_I: o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
         FMT_S: o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
         FMT_B: o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                         i_inst[30:25], i_inst[11:8], 1'b0};
         FMT_U: o_imm = {i_inst[31:12], 12'd0};
         FMT_J: o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                         i_inst[20], i_inst[30:21], 1'b0};
         default: o_imm = 32'd0;
      endcase
   end

endmodule

// File: rtl/asrv32_decoder.sv
// RV32I decode stage: one register stage between fetch and execute with
// stall/flush handshake. Register-file read addresses leave combinationally
// so operands arrive alongside the registered decode.
// Optional feature: define ASRV32_ILLEGAL_CHECK_EN to flag illegal encodings
// on o_illegal; otherwise o_illegal is tied low.
module asrv32_decoder
   import asrv32_pkg::*;
#(
   parameter int PC_WIDTH = 32
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [31:0]         i_inst,
   input  logic [PC_WIDTH-1:0] i_pc,
   input  logic                i_ce,
   input  logic                i_stall,
   input  logic                i_flush,
   output logic [4:0]          o_rs1_addr,
   output logic [4:0]          o_rs2_addr,
   output logic                o_ce_rd,
   output logic [4:0]          o_rd_addr,
   output logic [31:0]         o_imm,
   output logic [2:0]          o_funct3,
   output logic [10:0]         o_opcode,
   output logic                o_alt,
   output logic [PC_WIDTH-1:0] o_pc,
   output logic                o_ce,
   output logic                o_stall,
   output logic                o_illegal
);

   logic [4:0]          rd_addr_q, rd_addr_d;
   logic [31:0]         imm_q, imm_d;
   logic [2:0]          funct3_q;
   logic [NUM_CLS-1:0]  opcode_q, opcode_d;
   logic                alt_q, alt_d;
   logic [PC_WIDTH-1:0] pc_q;
   logic                ce_q;
   fmt_e                fmt_d;
   logic                stall;
   logic                accept;

   // Hold only while a valid instruction sits here; a flush always frees the stage
   assign stall  = i_stall & ce_q & ~i_flush;
   assign accept = i_ce & ~stall & ~i_flush;

   assign o_rs1_addr = i_inst[19:15];
   assign o_rs2_addr = i_inst[24:20];
   assign o_ce_rd    = i_ce & ~stall;
   assign o_stall    = stall;

   assign o_rd_addr = rd_addr_q;
   assign o_imm     = imm_q;
   assign o_funct3  = funct3_q;
   assign o_opcode  = opcode_q;
   assign o_alt     = alt_q;
   assign o_pc      = pc_q;
   assign o_ce      = ce_q;

   // Classify the opcode, pick immediate format, rd override and alt bit
   always_comb begin
      opcode_d  = '0;
      fmt_d     = FMT_NONE;
      rd_addr_d = i_inst[11:7];
      alt_d     = 1'b0;
      case (i_inst[6:0])
         OPC_LOAD: begin
            opcode_d[CLS_LOAD] = 1'b1;
            fmt_d              = FMT_I;
         end
         OPC_STORE: begin
            opcode_d[CLS_STORE] = 1'b1;
            fmt_d               = FMT_S;
            rd_addr_d           = 5'd0;
         end
         OPC_OPIMM: begin
            opcode_d[CLS_OPIMM] = 1'b1;
            fmt_d               = FMT_I;
            // inst[30] is only an opcode modifier for SLLI/SRLI/SRAI
            alt_d = i_inst[30] & (i_inst[13:12] == 2'b01);
         end
         OPC_OP: begin
            opcode_d[CLS_OP] = 1'b1;
            alt_d            = i_inst[30];
         end
         OPC_BRANCH: begin
            opcode_d[CLS_BRANCH] = 1'b1;
            fmt_d                = FMT_B;
            rd_addr_d            = 5'd0;
         end
         OPC_JAL: begin
            opcode_d[CLS_JAL] = 1'b1;
            fmt_d             = FMT_J;
         end
         OPC_JALR: begin
            opcode_d[CLS_JALR] = 1'b1;
            fmt_d              = FMT_I;
         end
         OPC_LUI: begin
            opcode_d[CLS_LUI] = 1'b1;
            fmt_d             = FMT_U;
         end
         OPC_AUIPC: begin
            opcode_d[CLS_AUIPC] = 1'b1;
            fmt_d               = FMT_U;
         end
         OPC_SYSTEM: begin
            opcode_d[CLS_SYSTEM] = 1'b1;
            fmt_d                = FMT_I;
         end
         OPC_FENCE: begin
            opcode_d[CLS_FENCE] = 1'b1;
            rd_addr_d           = 5'd0;
         end
         default: ;
      endcase
   end

   asrv32_imm_gen u_imm_gen (
      .i_inst (i_inst),
      .i_fmt  (fmt_d),
      .o_imm  (imm_d)
   );

   // Stage register: flush clears valid, stall holds, accept loads, else drain
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ce_q      <= 1'b0;
         rd_addr_q <= 5'd0;
         imm_q     <= 32'd0;
         funct3_q  <= 3'd0;
         opcode_q  <= '0;
         alt_q     <= 1'b0;
         pc_q      <= '0;
      end else if (i_flush) begin
         ce_q <= 1'b0;
      end else if (stall) begin
         ce_q <= ce_q;
      end else if (accept) begin
         ce_q      <= 1'b1;
         rd_addr_q <= rd_addr_d;
         imm_q     <= imm_d;
         funct3_q  <= i_inst[14:12];
         opcode_q  <= opcode_d;
         alt_q     <= alt_d;
         pc_q      <= i_pc;
      end else begin
         ce_q <= 1'b0;
      end
   end

`ifdef ASRV32_ILLEGAL_CHECK_EN
   logic illegal_q, illegal_d;

   // Unknown class, non-32-bit encoding, or an OP funct7 outside ADD/SUB space
   always_comb begin
      illegal_d = (opcode_d == '0) ||
                  (i_inst[1:0] != 2'b11) ||
                  (opcode_d[CLS_OP] && (i_inst[31:25] != 7'h00) &&
                   (i_inst[31:25] != 7'h20));
   end

   // Illegal flag follows the stage register; flush clears it
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         illegal_q <= 1'b0;
      end else if (i_flush) begin
         illegal_q <= 1'b0;
      end else if (accept) begin
         illegal_q <= illegal_d;
      end
   end

   assign o_illegal = illegal_q;
`else
   assign o_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_asrv32_decoder.sv
// Scoreboard bench for asrv32_decoder: a reference decode computes the
// expected stage contents when stimulus is driven; the result is queued and
// compared after the next rising edge. Builds with or without
// ASRV32_ILLEGAL_CHECK_EN.
module tb_asrv32_decoder;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [31:0] i_inst = 32'd0;
   logic [31:0] i_pc = 32'd0;
   logic        i_ce = 1'b0;
   logic        i_stall = 1'b0;
   logic        i_flush = 1'b0;
   logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
   logic        o_ce_rd, o_alt, o_ce, o_stall, o_illegal;
   logic [31:0] o_imm, o_pc;
   logic [2:0]  o_funct3;
   logic [10:0] o_opcode;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        ce;
      logic        known;
      logic        flushed;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [2:0]  f3;
      logic [10:0] opc;
      logic        alt;
      logic [31:0] pc;
      logic        ill;
   } exp_t;

   exp_t sb_q[$];
   exp_t m;

   asrv32_decoder #(.PC_WIDTH(32)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_inst     (i_inst),
      .i_pc       (i_pc),
      .i_ce       (i_ce),
      .i_stall    (i_stall),
      .i_flush    (i_flush),
      .o_rs1_addr (o_rs1_addr),
      .o_rs2_addr (o_rs2_addr),
      .o_ce_rd    (o_ce_rd),
      .o_rd_addr  (o_rd_addr),
      .o_imm      (o_imm),
      .o_funct3   (o_funct3),
      .o_opcode   (o_opcode),
      .o_alt      (o_alt),
      .o_pc       (o_pc),
      .o_ce       (o_ce),
      .o_stall    (o_stall),
      .o_illegal  (o_illegal)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t ref_dec(input logic [31:0] w, input logic [31:0] pc);
      exp_t e;
      logic [31:0] immi, imms, immb, immu, immj;
      logic [6:0]  f7;
      immi = {{20{w[31]}}, w[31:20]};
      imms = {{20{w[31]}}, w[31:25], w[11:7]};
      immb = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      immu = {w[31:12], 12'h000};
      immj = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      f7 = w[31:25];
      e.ce = 1'b1; e.known = 1'b1; e.flushed = 1'b0;
      e.rd = w[11:7]; e.imm = 32'd0; e.f3 = w[14:12]; e.opc = 11'd0;
      e.alt = 1'b0; e.pc = pc; e.ill = 1'b0;
      case (w[6:0])
         7'h03: begin e.opc = 11'h001; e.imm = immi; end
         7'h23: begin e.opc = 11'h002; e.imm = imms; e.rd = 5'd0; end
         7'h13: begin
            e.opc = 11'h004; e.imm = immi;
            if (w[14:12] == 3'd1 || w[14:12] == 3'd5) e.alt = w[30];
         end
         7'h33: begin e.opc = 11'h008; e.alt = w[30]; end
         7'h63: begin e.opc = 11'h010; e.imm = immb; e.rd = 5'd0; end
         7'h6F: begin e.opc = 11'h020; e.imm = immj; end
         7'h67: begin e.opc = 11'h040; e.imm = immi; end
         7'h37: begin e.opc = 11'h080; e.imm = immu; end
         7'h17: begin e.opc = 11'h100; e.imm = immu; end
         7'h73: begin e.opc = 11'h200; e.imm = immi; end
         7'h0F: begin e.opc = 11'h400; e.rd = 5'd0; end
         default: e.known = 1'b0;
      endcase
`ifdef ASRV32_ILLEGAL_CHECK_EN
      e.ill = (e.opc == 11'd0) || (w[1:0] != 2'b11) ||
              ((w[6:0] == 7'h33) && (f7 != 7'h00) && (f7 != 7'h20));
`else
      e.ill = (f7 == 7'h7F) && 1'b0;
`endif
      return e;
   endfunction

   task automatic check_out();
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 64'd1, 64'd0);
         return;
      end
      e = sb_q.pop_front();
      chk("o_ce", {63'd0, o_ce}, {63'd0, e.ce});
      if (e.ce) begin
         chk("o_pc", {32'd0, o_pc}, {32'd0, e.pc});
         chk("o_funct3", {61'd0, o_funct3}, {61'd0, e.f3});
         chk("o_opcode", {53'd0, o_opcode}, {53'd0, e.opc});
         chk("o_illegal", {63'd0, o_illegal}, {63'd0, e.ill});
         if (e.known) begin
            chk("o_rd_addr", {59'd0, o_rd_addr}, {59'd0, e.rd});
            chk("o_imm", {32'd0, o_imm}, {32'd0, e.imm});
            chk("o_alt", {63'd0, o_alt}, {63'd0, e.alt});
         end
      end else if (e.flushed) begin
         chk("o_illegal_flush", {63'd0, o_illegal}, 64'd0);
      end
   endtask

   // Drive one cycle from just after the falling edge; check after rising edge
   task automatic cyc(input logic [31:0] inst, input logic [31:0] pc,
                      input logic ce, input logic stall, input logic flush);
      logic e_stall;
      i_inst = inst; i_pc = pc; i_ce = ce; i_stall = stall; i_flush = flush;
      #1;
      e_stall = stall & m.ce & ~flush;
      chk("o_stall", {63'd0, o_stall}, {63'd0, e_stall});
      chk("o_ce_rd", {63'd0, o_ce_rd}, {63'd0, ce & ~e_stall});
      chk("o_rs1_addr", {59'd0, o_rs1_addr}, {59'd0, inst[19:15]});
      chk("o_rs2_addr", {59'd0, o_rs2_addr}, {59'd0, inst[24:20]});
      if (flush) begin
         m.ce = 1'b0; m.ill = 1'b0; m.flushed = 1'b1;
      end else if (e_stall) begin
         m.flushed = 1'b0;
      end else if (ce) begin
         m = ref_dec(inst, pc);
      end else begin
         m.ce = 1'b0; m.flushed = 1'b0;
      end
      sb_q.push_back(m);
      @(posedge i_clk);
      #1;
      check_out();
      @(negedge i_clk);
   endtask

   logic [31:0] pool [16] = '{
      32'hFFD08293, 32'h0021A423, 32'h40208033, 32'h00208033,
      32'h4050D713, 32'h00209093, 32'hFE208EE3, 32'h7FFFF06F,
      32'h800000EF, 32'h000080E7, 32'hABCDE537, 32'h00001597,
      32'h00000073, 32'h0FF0000F, 32'h02000033, 32'h00000000
   };

   initial begin
      logic [31:0] pc;
      logic [31:0] w;
      m = '{default: 0};
      // Reset state while i_rst_n is low
      #2;
      chk("rst_ce", {63'd0, o_ce}, 64'd0);
      chk("rst_illegal", {63'd0, o_illegal}, 64'd0);
      chk("rst_rd", {59'd0, o_rd_addr}, 64'd0);
      chk("rst_imm", {32'd0, o_imm}, 64'd0);
      chk("rst_opcode", {53'd0, o_opcode}, 64'd0);
      chk("rst_pc", {32'd0, o_pc}, 64'd0);
      chk("rst_alt", {63'd0, o_alt}, 64'd0);
      chk("rst_funct3", {61'd0, o_funct3}, 64'd0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // ADDI x5,x1,-3 accepted on first edge after reset release
      cyc(32'hFFD08293, 32'h100, 1'b1, 1'b0, 1'b0);
      chk("addi_ce", {63'd0, o_ce}, 64'd1);
      chk("addi_rd", {59'd0, o_rd_addr}, 64'd5);
      chk("addi_imm", {32'd0, o_imm}, 64'hFFFFFFFD);
      chk("addi_opimm", {63'd0, o_opcode[2]}, 64'd1);

      // SW x2,8(x3)
      cyc(32'h0021A423, 32'h104, 1'b1, 1'b0, 1'b0);
      chk("sw_imm", {32'd0, o_imm}, 64'd8);
      chk("sw_rd", {59'd0, o_rd_addr}, 64'd0);
      chk("sw_store", {53'd0, o_opcode}, 64'h002);

      // Stall three cycles with a new instruction waiting, then release
      for (int k = 0; k < 3; k++) begin
         cyc(32'h40208033, 32'h108, 1'b1, 1'b1, 1'b0);
         chk("stall_hold_imm", {32'd0, o_imm}, 64'd8);
      end
      cyc(32'h40208033, 32'h108, 1'b1, 1'b0, 1'b0);
      chk("release_sub", {53'd0, o_opcode}, 64'h008);
      chk("release_alt", {63'd0, o_alt}, 64'd1);

      // Stall and flush together: no backpressure, valid drops
      cyc(32'h00209093, 32'h10C, 1'b1, 1'b1, 1'b1);
      chk("flush_ce", {63'd0, o_ce}, 64'd0);

      // All-zero word
      cyc(32'h00000000, 32'h110, 1'b1, 1'b0, 1'b0);
      chk("zero_opcode", {53'd0, o_opcode}, 64'd0);
      chk("zero_ce", {63'd0, o_ce}, 64'd1);
`ifdef ASRV32_ILLEGAL_CHECK_EN
      chk("zero_illegal", {63'd0, o_illegal}, 64'd1);
`else
      chk("zero_illegal", {63'd0, o_illegal}, 64'd0);
`endif

      // Reload, then asynchronous reset mid-stall between edges
      cyc(32'hABCDE537, 32'h114, 1'b1, 1'b0, 1'b0);
      i_stall = 1'b1; i_ce = 1'b1;
      #1;
      chk("pre_rst_stall", {63'd0, o_stall}, 64'd1);
      i_rst_n = 1'b0;
      #1;
      chk("async_rst_ce", {63'd0, o_ce}, 64'd0);
      chk("async_rst_stall", {63'd0, o_stall}, 64'd0);
      chk("async_rst_imm", {32'd0, o_imm}, 64'd0);
      chk("async_rst_pc", {32'd0, o_pc}, 64'd0);
      chk("async_rst_opcode", {53'd0, o_opcode}, 64'd0);
      #1;
      i_rst_n = 1'b1;
      m = '{default: 0};

      // Back-to-back accepts, then randomized handshake traffic
      pc = 32'h200;
      for (int k = 0; k < 16; k++) begin
         cyc(pool[k], pc, 1'b1, 1'b0, 1'b0);
         pc += 4;
      end
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) == 0) w = $urandom;
         else w = pool[$urandom_range(0, 15)];
         cyc(w, pc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 7) == 0));
         pc += 4;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: sim time exceeded, expected finish");
      $fatal(1, "timeout");
   end

endmodule
